// File: rtl/wb_timer.sv
// wb_timer: Wishbone B4 pipelined responder wrapping a programmable
// down-counting timer with a prescaler, one-shot/periodic modes and a
// registered interrupt line.
//
// Ports:
//   wb_clk_i   - single clock
//   wb_rst_ni  - synchronous active-low reset
//   wb_cyc_i   - bus cycle active
//   wb_stb_i   - request strobe
//   wb_we_i    - 1 = write, 0 = read
//   wb_adr_i   - register word index (0 CTRL, 1 RELOAD, 2 COUNT, 3 STATUS)
//   wb_dat_i   - write data (truncated to COUNTER_WIDTH for RELOAD/COUNT)
//   wb_dat_o   - read data, non-zero only in the ack cycle of a read
//   wb_stall_o - high while a response is outstanding
//   wb_ack_o   - request completed (one cycle after acceptance)
//   int_timer  - registered STATUS.pending & CTRL.irq_en
//
// Handshake: a request is accepted on a clock edge where
// wb_cyc_i & wb_stb_i & !wb_stall_o. Write side-effects land on that same
// edge; wb_ack_o is high for exactly the following cycle, during which
// wb_stall_o is high, so at most one request is ever outstanding. The ack
// is not gated by wb_cyc_i: an initiator that abandons the cycle simply
// ignores it.

module wb_timer #(
  parameter int COUNTER_WIDTH = 32,
  parameter int PRESCALE      = 1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_stall_o,
  output logic        wb_ack_o,
  output logic        int_timer
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  state_t state, state_next;

  logic                     enable;
  logic                     periodic;
  logic                     irq_en;
  logic                     pending;
  logic [COUNTER_WIDTH-1:0] reload;
  logic [COUNTER_WIDTH-1:0] count;
  logic [PW-1:0]            presc;

  logic                     accept;
  logic                     ctrl_wr;
  logic                     reload_wr;
  logic                     count_wr;
  logic                     status_wr;
  logic                     tick;
  logic                     expire;
  logic [31:0]              rd_data;
  logic [COUNTER_WIDTH-1:0] wr_val;

  // Handshake FSM: state register.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Handshake FSM: next state and outputs. ack/stall decode straight from
  // the state flop, so they are glitch-free registered signals.
  always_comb begin
    state_next = state;
    wb_stall_o = 1'b0;
    wb_ack_o   = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        accept = wb_cyc_i & wb_stb_i;
        if (accept) state_next = ACK;
      end
      ACK: begin
        wb_stall_o = 1'b1;
        wb_ack_o   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign wr_val    = wb_dat_i[COUNTER_WIDTH-1:0];
  assign ctrl_wr   = accept & wb_we_i & (wb_adr_i == 4'd0);
  assign reload_wr = accept & wb_we_i & (wb_adr_i == 4'd1);
  assign count_wr  = accept & wb_we_i & (wb_adr_i == 4'd2);
  assign status_wr = accept & wb_we_i & (wb_adr_i == 4'd3);

  assign tick   = enable & (presc == PRESC_LAST);
  // A COUNT write in the same cycle overrides the tick entirely, so it
  // must also suppress the expiry it would otherwise cause.
  assign expire = tick & (count == '0) & ~count_wr;

  // Read mux sees register values before this cycle's update.
  always_comb begin
    rd_data = '0;
    case (wb_adr_i)
      4'd0:    rd_data = {29'd0, irq_en, periodic, enable};
      4'd1:    rd_data = 32'(reload);
      4'd2:    rd_data = 32'(count);
      4'd3:    rd_data = {31'd0, pending};
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      enable    <= 1'b0;
      periodic  <= 1'b0;
      irq_en    <= 1'b0;
      pending   <= 1'b0;
      reload    <= '0;
      count     <= '0;
      presc     <= '0;
      int_timer <= 1'b0;
      wb_dat_o  <= '0;
    end else begin
      // Read data is captured at acceptance and shown only in the ack cycle.
      wb_dat_o <= (accept & ~wb_we_i) ? rd_data : 32'd0;

      if (ctrl_wr) begin
        enable   <= wb_dat_i[0];
        periodic <= wb_dat_i[1];
        irq_en   <= wb_dat_i[2];
      end else if (expire & ~periodic) begin
        enable <= 1'b0;
      end

      if (reload_wr) reload <= wr_val;

      if (count_wr) begin
        presc <= '0;
      end else if (enable) begin
        presc <= tick ? '0 : presc + PW'(1);
      end

      // Periodic reload uses the RELOAD value from before any same-cycle
      // RELOAD write; one-shot expiry leaves COUNT parked at 0.
      if (count_wr) begin
        count <= wr_val;
      end else if (tick) begin
        if (count == '0) begin
          if (periodic) count <= reload;
        end else begin
          count <= count - COUNTER_WIDTH'(1);
        end
      end

      // Expiry beats a same-cycle clear.
      if (expire) begin
        pending <= 1'b1;
      end else if (status_wr & wb_dat_i[0]) begin
        pending <= 1'b0;
      end

      int_timer <= pending & irq_en;
    end
  end

endmodule

// File: tb/tb_wb_timer.sv
// Bench for wb_timer: two instances (PRESCALE=1 and PRESCALE=4) share one
// bus driver; sel chooses which one a transfer targets. The driver pushes
// the expected read data and ack cycle into queues at acceptance; a monitor
// pops and compares whenever the selected instance raises ack.

module tb_wb_timer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  adr = '0;
  logic [31:0] wdat = '0;
  logic        sel = 1'b0;

  logic [31:0] dat_a, dat_b;
  logic        stall_a, stall_b, ack_a, ack_b, int_a, int_b;
  logic [31:0] dat_s;
  logic        stall_s, ack_s;

  int cnt = 0;
  int checks = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  bit          chk_q[$];
  int          cyc_q[$];
  string       tag_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 1;

  wb_timer #(.COUNTER_WIDTH(32), .PRESCALE(1)) u_dut_a (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .wb_cyc_i   (cyc & ~sel),
    .wb_stb_i   (stb & ~sel),
    .wb_we_i    (we),
    .wb_adr_i   (adr),
    .wb_dat_i   (wdat),
    .wb_dat_o   (dat_a),
    .wb_stall_o (stall_a),
    .wb_ack_o   (ack_a),
    .int_timer  (int_a)
  );

  wb_timer #(.COUNTER_WIDTH(32), .PRESCALE(4)) u_dut_b (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .wb_cyc_i   (cyc & sel),
    .wb_stb_i   (stb & sel),
    .wb_we_i    (we),
    .wb_adr_i   (adr),
    .wb_dat_i   (wdat),
    .wb_dat_o   (dat_b),
    .wb_stall_o (stall_b),
    .wb_ack_o   (ack_b),
    .int_timer  (int_b)
  );

  assign dat_s   = sel ? dat_b : dat_a;
  assign stall_s = sel ? stall_b : stall_a;
  assign ack_s   = sel ? ack_b : ack_a;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wb_xfer(input logic [3:0] a, input logic w, input logic [31:0] d,
                         input logic [31:0] e, input bit c, input string tag);
    int waited;
    waited = 0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
    while (stall_s && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    if (stall_s) begin
      check({tag, "_stall_timeout"}, 32'(stall_s), 32'd0);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    chk_q.push_back(c);
    cyc_q.push_back(cnt);
    tag_q.push_back(tag);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e, input string tag);
    wb_xfer(a, 1'b0, 32'd0, e, 1'b1, tag);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input string tag);
    wb_xfer(a, 1'b1, d, 32'd0, 1'b0, tag);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (ack_s) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 32'(ack_s), 32'd0);
      end else begin
        logic [31:0] e;
        bit          c;
        int          cy;
        string       t;
        e  = exp_q.pop_front();
        c  = chk_q.pop_front();
        cy = cyc_q.pop_front();
        t  = tag_q.pop_front();
        if (c) check({t, "_data"}, dat_s, e);
        check({t, "_ack_cycle"}, 32'(cnt), 32'(cy));
        check({t, "_stall_in_ack"}, 32'(stall_s), 32'd1);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack_a", 32'(ack_a), 32'd0);
    check("rst_stall_a", 32'(stall_a), 32'd0);
    check("rst_dat_a", dat_a, 32'd0);
    check("rst_int_a", 32'(int_a), 32'd0);
    check("rst_int_b", 32'(int_b), 32'd0);
    rst_n = 1'b1;

    // All 16 addresses read 0 after reset.
    for (int i = 0; i < 16; i++) rd(4'(i), 32'd0, $sformatf("rst_rd%0d", i));

    // PRESCALE=1 one-shot with irq_en.
    wr(4'd2, 32'd3, "a_count_w");
    rd(4'd2, 32'd3, "a_count_init");
    wr(4'd0, 32'd5, "a_ctrl_w");
    rd(4'd2, 32'd2, "a_count_t2");
    rd(4'd2, 32'd0, "a_count_t4");
    @(negedge clk);
    check("a_int_before_rise", 32'(int_a), 32'd0);
    @(negedge clk);
    check("a_int_rise", 32'(int_a), 32'd1);
    rd(4'd3, 32'd1, "a_status_pending");
    rd(4'd0, 32'd4, "a_ctrl_enable_cleared");
    rd(4'd2, 32'd0, "a_count_hold");
    wr(4'd3, 32'd1, "a_status_clr");
    rd(4'd3, 32'd0, "a_status_cleared");
    check("a_int_cleared", 32'(int_a), 32'd0);
    @(negedge clk);
    @(negedge clk);
    sel = 1'b1;

    // PRESCALE=4 periodic, RELOAD=2: expiry every 12 cycles.
    wr(4'd1, 32'd2, "b_reload_w");
    wr(4'd2, 32'd2, "b_count_w");
    wr(4'd0, 32'd7, "b_ctrl_w");
    rd(4'd2, 32'd2, "b_q2");
    rd(4'd2, 32'd2, "b_q4");
    rd(4'd2, 32'd1, "b_q6");
    rd(4'd2, 32'd1, "b_q8");
    rd(4'd2, 32'd0, "b_q10");
    rd(4'd2, 32'd0, "b_q12");
    rd(4'd2, 32'd2, "b_q14_reload");
    check("b_int_high", 32'(int_b), 32'd1);
    rd(4'd3, 32'd1, "b_status_q16");
    wr(4'd3, 32'd1, "b_status_clr_q18");
    @(negedge clk);
    check("b_int_hold", 32'(int_b), 32'd1);
    @(negedge clk);
    check("b_int_fall", 32'(int_b), 32'd0);
    @(negedge clk);

    // STATUS clear lands on the expiry edge: set wins.
    rd(4'd2, 32'd0, "b_q22");
    wr(4'd3, 32'd1, "b_clr_at_expiry_q24");
    rd(4'd3, 32'd1, "b_status_set_wins");
    check("b_int_after_race", 32'(int_b), 32'd1);

    // COUNT write lands on the expiry tick: write wins, no expiry.
    wr(4'd3, 32'd1, "b_status_clr_q28");
    rd(4'd2, 32'd1, "b_q30");
    rd(4'd2, 32'd1, "b_q32");
    rd(4'd2, 32'd0, "b_q34");
    wr(4'd2, 32'd7, "b_count_w_at_expiry");
    rd(4'd3, 32'd0, "b_status_unchanged");
    rd(4'd2, 32'd7, "b_q40");
    rd(4'd2, 32'd6, "b_q42");
    rd(4'd2, 32'd6, "b_q44");
    // COUNT write mid-prescale restarts the prescaler.
    wr(4'd2, 32'd5, "b_count_w_mid_presc");
    rd(4'd2, 32'd5, "b_q48");
    rd(4'd2, 32'd5, "b_q50");
    rd(4'd2, 32'd4, "b_q52");
    check("b_int_low", 32'(int_b), 32'd0);

    // Reset on the accepting edge of a read with the timer running.
    @(negedge clk);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 4'd2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_ack_edge", 32'(ack_b), 32'd0);
    @(negedge clk);
    check("mid_rst_ack", 32'(ack_b), 32'd0);
    check("mid_rst_stall", 32'(stall_b), 32'd0);
    check("mid_rst_dat", dat_b, 32'd0);
    check("mid_rst_int", 32'(int_b), 32'd0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rd(4'd2, 32'd0, "post_rst_count");
    rd(4'd0, 32'd0, "post_rst_ctrl");
    rd(4'd2, 32'd0, "post_rst_count_idle");
    check("post_rst_int", 32'(int_b), 32'd0);

    repeat (3) @(negedge clk);
    check("outstanding_acks", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
